// File: rtl/alu_issue_wb_stage.sv
// Operand-fetch / writeback stage around an external 8-bit ALU: IDLE accepts and registers
// operands, EXEC captures the ALU result into the register file and flags. Option: ALU_ISSUE_IMM_EN.
module alu_issue_wb_stage #(
    parameter int NREGS = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
`ifdef ALU_ISSUE_IMM_EN
    input  logic          in_use_imm,
    input  logic [7:0]    in_imm,
`endif
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_opcode,
    input  logic [AW-1:0] in_rd,
    input  logic [AW-1:0] in_rs1,
    input  logic [AW-1:0] in_rs2,
    input  logic          in_use_carry,
    output logic [7:0]    alu_x,
    output logic [7:0]    alu_y,
    output logic [3:0]    alu_opcode,
    output logic          alu_cin,
    input  logic [7:0]    alu_z,
    input  logic          alu_cout,
    input  logic          alu_xby,
    input  logic          alu_ybx,
    input  logic          alu_xey,
    output logic          wb_valid,
    output logic [AW-1:0] wb_rd,
    output logic [7:0]    wb_data,
    output logic          flag_c,
    output logic          flag_z,
    output logic          flag_gt,
    output logic          flag_lt,
    output logic          flag_eq,
    output logic          err,
    input  logic [AW-1:0] dbg_addr,
    output logic [7:0]    dbg_data
);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t        state_q, state_d;
    logic [7:0]    regs_q [NREGS];
    logic [7:0]    regs_d [NREGS];
    logic [7:0]    alu_x_q, alu_x_d;
    logic [7:0]    alu_y_q, alu_y_d;
    logic [3:0]    alu_opcode_q, alu_opcode_d;
    logic          alu_cin_q, alu_cin_d;
    logic [AW-1:0] rd_q, rd_d;
    logic          wb_valid_q, wb_valid_d;
    logic [AW-1:0] wb_rd_q, wb_rd_d;
    logic [7:0]    wb_data_q, wb_data_d;
    logic          err_q, err_d;
    logic          flag_c_q, flag_c_d;
    logic          flag_z_q, flag_z_d;
    logic          flag_gt_q, flag_gt_d;
    logic          flag_lt_q, flag_lt_d;
    logic          flag_eq_q, flag_eq_d;
    logic [7:0]    operand_y;

    // Handshake: an instruction transfers on a rising edge where in_valid && in_ready;
    // in_ready is high only in IDLE, and the source must hold the instruction until then.
    always_comb begin
        operand_y = regs_q[in_rs2];
`ifdef ALU_ISSUE_IMM_EN
        if (in_use_imm) begin
            operand_y = in_imm;
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        regs_d       = regs_q;
        alu_x_d      = alu_x_q;
        alu_y_d      = alu_y_q;
        alu_opcode_d = alu_opcode_q;
        alu_cin_d    = alu_cin_q;
        rd_d         = rd_q;
        wb_valid_d   = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        err_d        = 1'b0;
        flag_c_d     = flag_c_q;
        flag_z_d     = flag_z_q;
        flag_gt_d    = flag_gt_q;
        flag_lt_d    = flag_lt_q;
        flag_eq_d    = flag_eq_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    alu_x_d      = regs_q[in_rs1];
                    alu_y_d      = operand_y;
                    alu_opcode_d = in_opcode;
                    alu_cin_d    = in_use_carry & flag_c_q;
                    rd_d         = in_rd;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                if (alu_opcode_q <= 4'b1000) begin
                    regs_d[rd_q] = alu_z;
                    wb_valid_d   = 1'b1;
                    wb_rd_d      = rd_q;
                    wb_data_d    = alu_z;
                    flag_z_d     = (alu_z == 8'h00);
                    flag_gt_d    = alu_xby;
                    flag_lt_d    = alu_ybx;
                    flag_eq_d    = alu_xey;
                    // Only the add opcode produces a meaningful carry.
                    if (alu_opcode_q == 4'b0000) begin
                        flag_c_d = alu_cout;
                    end
                end else begin
                    err_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= 8'h00;
            end
            alu_x_q      <= 8'h00;
            alu_y_q      <= 8'h00;
            alu_opcode_q <= 4'b0000;
            alu_cin_q    <= 1'b0;
            rd_q         <= '0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= 8'h00;
            err_q        <= 1'b0;
            flag_c_q     <= 1'b0;
            flag_z_q     <= 1'b0;
            flag_gt_q    <= 1'b0;
            flag_lt_q    <= 1'b0;
            flag_eq_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            regs_q       <= regs_d;
            alu_x_q      <= alu_x_d;
            alu_y_q      <= alu_y_d;
            alu_opcode_q <= alu_opcode_d;
            alu_cin_q    <= alu_cin_d;
            rd_q         <= rd_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            err_q        <= err_d;
            flag_c_q     <= flag_c_d;
            flag_z_q     <= flag_z_d;
            flag_gt_q    <= flag_gt_d;
            flag_lt_q    <= flag_lt_d;
            flag_eq_q    <= flag_eq_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign alu_x      = alu_x_q;
    assign alu_y      = alu_y_q;
    assign alu_opcode = alu_opcode_q;
    assign alu_cin    = alu_cin_q;
    assign wb_valid   = wb_valid_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign err        = err_q;
    assign flag_c     = flag_c_q;
    assign flag_z     = flag_z_q;
    assign flag_gt    = flag_gt_q;
    assign flag_lt    = flag_lt_q;
    assign flag_eq    = flag_eq_q;
    assign dbg_data   = regs_q[dbg_addr];

endmodule
